uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, sets the character width on both request ports and on tx_data.
REQ-002 Parameter TIMEOUT_CYC, default 65535, sets the BUSY-state watchdog limit in clk cycles; it is used only with UART_TX_ARB_TIMEOUT_EN.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req0_valid / req0_data, input, 1 / DATA_W: requester 0 (core LSU) character offer.
REQ-006 Port req0_ready, output, 1: requester 0 character accepted this cycle.
REQ-007 Port req1_valid / req1_data, input, 1 / DATA_W: requester 1 (debug) character offer.
REQ-008 Port req1_ready, output, 1: requester 1 character accepted this cycle.
REQ-009 Port tx_data, output, DATA_W: registered character presented to the transmit datapath.
REQ-010 Port load, output, 1: one-cycle pulse telling the transmit datapath to capture tx_data.
REQ-011 Port tx_start, output, 1: one-cycle pulse that starts serialisation.
REQ-012 Port data_transmitted, input, 1: datapath indicates the frame is complete.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port grant_id, output, 1: requester that owns the current transfer.
REQ-015 Port err_timeout, output, 1: one-cycle watchdog pulse; tied to 0 when the macro is absent.

Function
REQ-016 The FSM SHALL have four states, IDLE -> LOAD -> START -> BUSY -> IDLE, with Moore outputs.
REQ-017 In IDLE, when any reqN_valid is high, it SHALL raise reqN_ready for exactly the chosen requester (combinationally), register reqN_data into tx_data, set grant_id, and move to LOAD.
REQ-018 Arbitration SHALL be round-robin: a lone valid requester wins; when both are valid, the one not in last_grant wins.
REQ-019 last_grant SHALL update to grant_id on acceptance.
REQ-020 LOAD SHALL assert load for one cycle; START SHALL assert tx_start for one cycle.
REQ-021 Latency: acceptance in cycle N gives load in N+1, tx_start in N+2, and BUSY from N+3.
REQ-022 data_transmitted SHALL be ignored in IDLE, LOAD and START.
REQ-023 In BUSY, data_transmitted SHALL move the FSM to IDLE on the next edge; the earliest next acceptance is the cycle after that.
REQ-024 Both reqN_ready outputs SHALL be 0 in all states except IDLE; tx_data SHALL hold stable from LOAD through BUSY.
REQ-025 A requester dropping valid while not ready SHALL have no effect and leave no residue.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, tx_data=0, grant_id=0, last_grant=1 (so requester 0 wins the first tie), watchdog counter=0.
REQ-027 During reset: load, tx_start, busy, err_timeout and both readies SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no completion pulse.

Configuration
REQ-029 Macro UART_TX_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to BUSY and count each BUSY cycle.
REQ-030 With the macro, if the counter reaches TIMEOUT_CYC-1 without data_transmitted, the block SHALL pulse err_timeout for one cycle and return to IDLE; data_transmitted in that same cycle SHALL win with no error.
REQ-031 Macro undefined: there SHALL be no counter, BUSY SHALL wait indefinitely, and err_timeout SHALL be constant 0.

Structure
REQ-032 Package uart_tx_pkg SHALL hold the state enum (IDLE, LOAD, START, BUSY), the DATA_W default and the TIMEOUT_CYC default.
REQ-033 Sub-module rr_arb2 SHALL implement the two-input round-robin choice (inputs: valids and last_grant; outputs: grant_valid and grant_id), purely combinational.

Verification
REQ-034 Single request: req0_valid=1, data 0x41 in IDLE -> req0_ready in cycle 0, load in 1, tx_start in 2, tx_data=0x41, busy until one cycle after data_transmitted.
REQ-035 Simultaneous requests from reset: both valid, 0x55/0xAA -> 0x55 sent first (grant_id=0), then 0xAA (grant_id=1); held continuously, they alternate 0,1,0,1.
REQ-036 Early done: data_transmitted pulsed during LOAD and START -> ignored; FSM stays in BUSY until a later pulse.
REQ-037 Reset mid-BUSY: reset low for 2 cycles -> busy=0, outputs 0, grant_id=0; the next tie is granted to requester 0.
REQ-038 Timeout with macro, TIMEOUT_CYC=16: no data_transmitted -> err_timeout pulse 16 cycles after BUSY entry, then IDLE; without macro -> BUSY persists for 1000 cycles.
REQ-039 Withdrawn offer: req1_valid high for one cycle during BUSY then low -> no req1_ready and no transfer for requester 1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and defaults for the UART transmit arbiter
package uart_tx_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input combinational round-robin choice
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        grant_valid = |valid;
        if (valid == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid[1];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester UART transmit arbiter; optional BUSY watchdog under UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              load,
    output logic              tx_start,
    input  logic              data_transmitted,
    output logic              busy,
    output logic              grant_id,
    output logic              err_timeout
);

    // The watchdog counter is 16 bits wide, so its terminal count must fit.
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be within 2..65536");
    end

    tx_state_e state;
    tx_state_e state_nxt;
    logic      last_grant;
    logic      arb_valid;
    logic      arb_id;
    logic      accept;
    logic      timeout_hit;

    rr_arb2 u_rr_arb2 (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    assign accept = req0_ready | req1_ready;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational handshake; readies stay low while reset is held.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid && reset) begin
                    req0_ready = ~arb_id;
                    req1_ready = arb_id;
                    state_nxt  = LOAD;
                end
            end
            LOAD:  state_nxt = START;
            START: state_nxt = BUSY;
            BUSY: begin
                if (data_transmitted || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winning character and owner; held until the next acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            tx_data    <= arb_id ? req1_data : req0_data;
            grant_id   <= arb_id;
            last_grant <= arb_id;
        end
    end

    assign load     = (state == LOAD);
    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_cnt;
    logic        err_q;

    assign timeout_hit = (state == BUSY) && (wd_cnt == WD_LAST);
    assign err_timeout = err_q;

    // Watchdog: cleared while in START so the first BUSY cycle reads zero; completion beats expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout_hit && !data_transmitted;
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == BUSY) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
